// File: rtl/fifo_pkg.sv
// fifo_pkg: skid-state encoding, depth derivation and Gray/binary helpers for the async FIFO.
// Pointer helpers take zero-extended pointers of any width up to PTR_MAX bits.
package fifo_pkg;
   localparam int PTR_MAX = 32;
   typedef logic [PTR_MAX-1:0] ptr_t;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = g;
      for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/fifo_wr_frontend_sync.sv
// sync_2ff: two-flop synchroniser, no logic between the stages.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
endmodule

// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: write-domain skid buffer, read-pointer sync and fill level for the async FIFO.
// Optional macro WR_FRONTEND_STATS_EN adds saturating accept/stall counters.
module fifo_wr_frontend
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int AF_MARGIN  = 1
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   input  logic [ADDR_WIDTH:0]   wptr_bin,
   input  logic                  wfull,
   output logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic                  winc,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  walmost_full
`ifdef WR_FRONTEND_STATS_EN
   ,
   output logic [31:0]           wstat_accepts,
   output logic [31:0]           wstat_stall_cycles
`endif
);
   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
   skid_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic                  s_ready_q, s_ready_d, walmost_full_q, walmost_full_d;
   logic [ADDR_WIDTH:0]   wlevel_q, wlevel_d;
   logic                  accept, pop;
   sync_2ff #(.WIDTH(ADDR_WIDTH + 1)) u_rptr_sync (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (rptr_gray),
      .q     (wq2_rptr)
   );
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) state_q <= EMPTY;
      else state_q <= state_d;
   always_comb begin
      state_d = (state_q == EMPTY) ? (accept ? ONE : EMPTY) :
                (state_q == ONE)   ? ((accept && !pop) ? TWO : (pop && !accept) ? EMPTY : ONE) :
                (pop ? ONE : TWO);
   end
   always_comb begin
      winc  = (state_q != EMPTY) && !wfull;
      wdata = ent0_q;
   end
   // ent0 is always the head; a simultaneous accept+pop in ONE replaces it directly.
   always_comb begin
      accept         = s_valid && s_ready_q;
      pop            = winc;
      ent0_d         = (accept && (state_q == EMPTY || (state_q == ONE && pop))) ? s_data :
                       (state_q == TWO && pop) ? ent1_q : ent0_q;
      ent1_d         = (state_q == ONE && accept && !pop) ? s_data : ent1_q;
      s_ready_d      = state_d != TWO;
      wlevel_d       = (ADDR_WIDTH+1)'(ptr_t'(wptr_bin) - gray2bin(ptr_t'(wq2_rptr)));
      walmost_full_d = wlevel_d >= AF_THRESH;
   end
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) begin
         ent0_q         <= '0;
         ent1_q         <= '0;
         s_ready_q      <= 1'b0;
         wlevel_q       <= '0;
         walmost_full_q <= 1'b0;
      end else begin
         ent0_q         <= ent0_d;
         ent1_q         <= ent1_d;
         s_ready_q      <= s_ready_d;
         wlevel_q       <= wlevel_d;
         walmost_full_q <= walmost_full_d;
      end
   assign s_ready      = s_ready_q;
   assign wlevel       = wlevel_q;
   assign walmost_full = walmost_full_q;
`ifdef WR_FRONTEND_STATS_EN
   logic [31:0] acc_q, acc_d, stall_q, stall_d;
   always_comb begin
      acc_d   = (accept && acc_q != '1) ? acc_q + 32'd1 : acc_q;
      stall_d = (s_valid && !s_ready_q && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   end
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) begin
         acc_q   <= '0;
         stall_q <= '0;
      end else begin
         acc_q   <= acc_d;
         stall_q <= stall_d;
      end
   assign wstat_accepts      = acc_q;
   assign wstat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fifo_wr_frontend.sv
// tb_fifo_wr_frontend: directed scoreboard bench for fifo_wr_frontend.
module tb_fifo_wr_frontend;
   localparam int AW = 3;
   localparam int DW = 8;
   logic          wclk = 1'b0, wrst_n = 1'b0, s_valid = 1'b0, wfull = 1'b0;
   logic          s_ready, winc, walmost_full;
   logic [DW-1:0] s_data = '0, wdata;
   logic [AW:0]   rptr_gray = '0, wptr_bin = '0, wq2_rptr, wlevel;
`ifdef WR_FRONTEND_STATS_EN
   logic [31:0]   wstat_accepts, wstat_stall_cycles;
`endif
   int            checks = 0, errors = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] nxt;
   logic          acc;
   always #5 wclk = ~wclk;
   fifo_wr_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_MARGIN(1)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .rptr_gray    (rptr_gray),
      .wptr_bin     (wptr_bin),
      .wfull        (wfull),
      .wq2_rptr     (wq2_rptr),
      .winc         (winc),
      .wdata        (wdata),
      .wlevel       (wlevel),
      .walmost_full (walmost_full)
`ifdef WR_FRONTEND_STATS_EN
      ,
      .wstat_accepts      (wstat_accepts),
      .wstat_stall_cycles (wstat_stall_cycles)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One cycle: drive at negedge, check the head against the scoreboard, record any accept.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic f, input int exp_winc,
                       output logic accepted);
      @(negedge wclk);
      s_valid = v;
      s_data  = d;
      wfull   = f;
      #1;
      if (exp_winc >= 0) chk("winc", 32'(winc), 32'(exp_winc));
      if (winc) begin
         if (sb.size() == 0) chk("winc_with_empty_scoreboard", 32'(winc), 32'd0);
         else chk("wdata", 32'(wdata), 32'(sb.pop_front()));
      end
      accepted = v && s_ready;
      if (accepted) sb.push_back(d);
   endtask
   initial begin
      rptr_gray = 4'b0011;
      wptr_bin  = 4'b0101;
      repeat (2) @(negedge wclk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_winc", 32'(winc), 32'd0);
      chk("rst_wq2_rptr", 32'(wq2_rptr), 32'd0);
      chk("rst_wlevel", 32'(wlevel), 32'd0);
      chk("rst_walmost_full", 32'(walmost_full), 32'd0);
`ifdef WR_FRONTEND_STATS_EN
      chk("rst_stat_acc", wstat_accepts, 32'd0);
      chk("rst_stat_stall", wstat_stall_cycles, 32'd0);
`endif
      @(negedge wclk);
      wrst_n    = 1'b1;
      rptr_gray = '0;
      wptr_bin  = '0;
      #1;
      chk("s_ready_before_edge", 32'(s_ready), 32'd0);
      step(1'b0, '0, 1'b0, 0, acc);
      chk("s_ready_first_edge", 32'(s_ready), 32'd1);
      nxt = 8'h01;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, nxt, 1'b0, (i == 0) ? 0 : 1, acc);
         if (acc) nxt++;
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, nxt, 1'b1, 0, acc);
         if (acc) nxt++;
         if (i == 1) chk("s_ready_under_wfull", 32'(s_ready), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, nxt, 1'b0, 1, acc);
         if (acc) nxt++;
      end
      for (int i = 0; i < 6 && sb.size() > 0; i++) step(1'b0, '0, 1'b0, -1, acc);
      chk("drain_1", 32'(sb.size()), 32'd0);
      @(negedge wclk);
      wptr_bin = 4'b0001;
      repeat (2) @(negedge wclk);
      #1;
      chk("level_pre_sync", 32'(wlevel), 32'd1);
      @(negedge wclk);
      rptr_gray = 4'b0001;
      @(negedge wclk);
      #1;
      chk("sync_edge1", 32'(wq2_rptr), 32'd0);
      @(negedge wclk);
      #1;
      chk("sync_edge2", 32'(wq2_rptr), 32'd1);
      chk("level_edge2", 32'(wlevel), 32'd1);
      @(negedge wclk);
      #1;
      chk("level_edge3", 32'(wlevel), 32'd0);
      @(negedge wclk);
      wptr_bin  = 4'b0010;
      rptr_gray = 4'b1001;
      repeat (3) @(negedge wclk);
      #1;
      chk("level_wrap", 32'(wlevel), 32'd4);
      chk("af_wrap", 32'(walmost_full), 32'd0);
      @(negedge wclk);
      wptr_bin = 4'b0101;
      @(negedge wclk);
      #1;
      chk("level_seven", 32'(wlevel), 32'd7);
      chk("af_seven", 32'(walmost_full), 32'd1);
      step(1'b1, 8'hE1, 1'b1, 0, acc);
      step(1'b1, 8'hE2, 1'b1, 0, acc);
      @(negedge wclk);
      #1;
      chk("two_s_ready", 32'(s_ready), 32'd0);
      wrst_n    = 1'b0;
      wfull     = 1'b0;
      s_valid   = 1'b0;
      rptr_gray = '0;
      wptr_bin  = '0;
      #1;
      chk("midrst_winc", 32'(winc), 32'd0);
      chk("midrst_wlevel", 32'(wlevel), 32'd0);
      chk("midrst_af", 32'(walmost_full), 32'd0);
      chk("midrst_wq2", 32'(wq2_rptr), 32'd0);
      sb.delete();
      @(negedge wclk);
      wrst_n = 1'b1;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd0);
      chk("post_rst_wlevel", 32'(wlevel), 32'd0);
      step(1'b0, '0, 1'b0, 0, acc);
      chk("post_rst_s_ready_edge", 32'(s_ready), 32'd1);
      nxt = 8'hA0;
      for (int i = 0; i < 9; i++) begin
         step(1'b1, nxt, 1'b0, (i == 0) ? 0 : 1, acc);
         if (i == 1) chk("first_post_rst_word", 32'(wdata), 32'hA0);
         if (acc) nxt++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, nxt, 1'b1, 0, acc);
         if (acc) nxt++;
      end
      for (int i = 0; i < 6 && sb.size() > 0; i++) step(1'b0, '0, 1'b0, -1, acc);
      chk("drain_2", 32'(sb.size()), 32'd0);
`ifdef WR_FRONTEND_STATS_EN
      chk("stat_accepts", wstat_accepts, 32'd10);
      chk("stat_stalls", wstat_stall_cycles, 32'd3);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
